execute_mdu: RTL and testbench

Parametrised execute stage for the five-stage pipeline, successor to the single-cycle execute stage. It keeps operand forwarding, ALU operand selection and the combinational `ALU` instance, with two extensions. Forwarding is generalised to `FWD_N` sources of `XLEN` bits. A multi-cycle iterative multiply/divide unit (MDU) raises `busy` so the hazard unit stalls IF/ID/EX until the result is ready. It sits between the ID/EX and EX/MEM pipeline registers.

---
 rtl/execute_mdu.sv | 208 ++++++++++++++++++++
 tb/tb_execute_mdu.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_mdu.sv
// EX stage: N-source operand forwarding, combinational ALU and, when EXECUTE_MDU_EN is
// defined, an iterative radix-2 multiply/divide unit that stalls the pipeline via busy.

module ALU #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic [3:0]      op,
   output logic [XLEN-1:0] y,
   output logic            f
);
   localparam int SW = $clog2(XLEN);

   logic [SW-1:0] shamt;
   assign shamt = b[SW-1:0];

   // Ops 0-9 produce a value, ops 10-15 are branch compares that only drive the flag.
   always_comb begin
      y = '0;
      f = 1'b0;
      case (op)
         4'd0:  y = a + b;
         4'd1:  y = a - b;
         4'd2:  y = a & b;
         4'd3:  y = a | b;
         4'd4:  y = a ^ b;
         4'd5:  y = a << shamt;
         4'd6:  y = a >> shamt;
         4'd7:  y = $signed(a) >>> shamt;
         4'd8:  y = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
         4'd9:  y = {{(XLEN-1){1'b0}}, a < b};
         4'd10: f = (a == b);
         4'd11: f = (a != b);
         4'd12: f = ($signed(a) < $signed(b));
         4'd13: f = ($signed(a) >= $signed(b));
         4'd14: f = (a < b);
         4'd15: f = (a >= b);
         default: ;
      endcase
   end
endmodule

module execute_mdu #(
   parameter  int XLEN  = 32,
   parameter  int FWD_N = 2,
   localparam int FSW   = $clog2(FWD_N + 1)
) (
   input  logic                  cpu_clk,
   input  logic                  cpu_rst,
   input  logic                  valid_in,
   input  logic                  flush,
   input  logic [XLEN-1:0]       rf_rD1,
   input  logic [XLEN-1:0]       rf_rD2,
   input  logic [XLEN-1:0]       pc,
   input  logic [XLEN-1:0]       ext,
   input  logic                  alua_sel,
   input  logic                  alub_sel,
   input  logic [3:0]            alu_op,
   input  logic                  md_en,
   input  logic [2:0]            md_op,
   input  logic [FSW-1:0]        forward_a,
   input  logic [FSW-1:0]        forward_b,
   input  logic [FWD_N*XLEN-1:0] fwd_data,
   output logic [XLEN-1:0]       ex_result,
   output logic                  alu_f,
   output logic [XLEN-1:0]       alu_src1,
   output logic [XLEN-1:0]       alu_src2,
   output logic                  busy
);
   localparam logic ALUA_PC   = 1'b1;
   localparam logic ALUB_SEXT = 1'b1;

   logic [XLEN-1:0] alu_a;
   logic [XLEN-1:0] alu_b;
   logic [XLEN-1:0] alu_y;

   // Out-of-range selects fall through to the register file value.
   always_comb begin
      alu_src1 = rf_rD1;
      alu_src2 = rf_rD2;
      for (int k = 1; k <= FWD_N; k++) begin
         if (int'(forward_a) == k) alu_src1 = fwd_data[(k-1)*XLEN +: XLEN];
         if (int'(forward_b) == k) alu_src2 = fwd_data[(k-1)*XLEN +: XLEN];
      end
   end

   assign alu_a = (alua_sel == ALUA_PC)   ? pc  : alu_src1;
   assign alu_b = (alub_sel == ALUB_SEXT) ? ext : alu_src2;

   ALU #(.XLEN(XLEN)) u_alu (
      .a  (alu_a),
      .b  (alu_b),
      .op (alu_op),
      .y  (alu_y),
      .f  (alu_f)
   );

`ifdef EXECUTE_MDU_EN
   typedef enum logic [1:0] {IDLE, CALC, DONE} mdu_state_t;
   localparam int CW = $clog2(XLEN);

   mdu_state_t        state, state_next;
   logic [CW-1:0]     cnt;
   logic [2*XLEN-1:0] acc, acc_step, prod;
   logic [XLEN-1:0]   opnd, result, result_next, quo, rem, mag_a, mag_b;
   logic [XLEN:0]     mul_sum, div_trial, div_diff;
   logic [2:0]        op_q;
   logic              neg_q, div_zero_q, issue, last, div_ge;
   logic              a_signed, b_signed, a_neg, b_neg, neg_issue;

   assign issue = valid_in & md_en & ~flush;
   assign last  = (cnt == CW'(XLEN - 1));

   always_ff @(posedge cpu_clk or posedge cpu_rst) begin
      if (cpu_rst) state <= IDLE;
      else         state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (flush) state_next = IDLE;
      else begin
         case (state)
            IDLE:    if (issue) state_next = CALC;
            CALC:    if (last)  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   always_comb begin
      busy      = ~cpu_rst & (((state == IDLE) & issue) | (state == CALC));
      ex_result = (state == DONE) ? result : alu_y;
   end

   // Operands become magnitudes at issue; the sign is re-applied after the last step.
   always_comb begin
      if (md_op[2]) begin
         a_signed = ~md_op[0];
         b_signed = ~md_op[0];
      end else begin
         a_signed = (md_op[1:0] == 2'b01) | (md_op[1:0] == 2'b10);
         b_signed = (md_op[1:0] == 2'b01);
      end
      a_neg     = a_signed & alu_src1[XLEN-1];
      b_neg     = b_signed & alu_src2[XLEN-1];
      mag_a     = a_neg ? -alu_src1 : alu_src1;
      mag_b     = b_neg ? -alu_src2 : alu_src2;
      neg_issue = (md_op[2] & md_op[1]) ? a_neg : (a_neg ^ b_neg);
   end

   // acc holds {partial product, multiplier} or {partial remainder, dividend/quotient}.
   always_comb begin
      mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + ({1'b0, opnd} & {(XLEN+1){acc[0]}});
      div_trial = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
      div_diff  = div_trial - {1'b0, opnd};
      div_ge    = ~div_diff[XLEN];
      if (op_q[2])
         acc_step = {div_ge ? div_diff[XLEN-1:0] : div_trial[XLEN-1:0], acc[XLEN-2:0], div_ge};
      else
         acc_step = {mul_sum, acc[XLEN-1:1]};
   end

   always_comb begin
      prod = neg_q ? -acc_step : acc_step;
      quo  = neg_q ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
      rem  = neg_q ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
      case (op_q)
         3'b000:                 result_next = prod[XLEN-1:0];
         3'b001, 3'b010, 3'b011: result_next = prod[2*XLEN-1:XLEN];
         3'b100, 3'b101:         result_next = div_zero_q ? '1 : quo;
         default:                result_next = rem;
      endcase
   end

   always_ff @(posedge cpu_clk or posedge cpu_rst) begin
      if (cpu_rst) begin
         cnt        <= '0;
         acc        <= '0;
         opnd       <= '0;
         result     <= '0;
         op_q       <= '0;
         neg_q      <= 1'b0;
         div_zero_q <= 1'b0;
      end else if (!flush) begin
         if (state == IDLE && issue) begin
            op_q       <= md_op;
            cnt        <= '0;
            acc        <= {{XLEN{1'b0}}, md_op[2] ? mag_a : mag_b};
            opnd       <= md_op[2] ? mag_b : mag_a;
            neg_q      <= neg_issue;
            div_zero_q <= (alu_src2 == '0);
         end else if (state == CALC) begin
            acc <= acc_step;
            cnt <= cnt + 1'b1;
            if (last) result <= result_next;
         end
      end
   end
`else
   logic unused_mdu;
   assign unused_mdu = ^{cpu_clk, cpu_rst, valid_in, flush, md_en, md_op};
   assign busy       = 1'b0;
   assign ex_result  = alu_y;
`endif
endmodule

// File: tb/tb_execute_mdu.sv
// Randomized self-checking bench for execute_mdu; MDU scenarios run only when EXECUTE_MDU_EN is defined.

module tb_execute_mdu;
   localparam int XLEN  = 32;
   localparam int FWD_N = 2;
   localparam int FSW   = 2;

   logic                  cpu_clk, cpu_rst, valid_in, flush;
   logic [XLEN-1:0]       rf_rD1, rf_rD2, pc, ext;
   logic                  alua_sel, alub_sel;
   logic [3:0]            alu_op;
   logic                  md_en;
   logic [2:0]            md_op;
   logic [FSW-1:0]        forward_a, forward_b;
   logic [FWD_N*XLEN-1:0] fwd_data;
   logic [XLEN-1:0]       ex_result, alu_src1, alu_src2;
   logic                  alu_f, busy;
   int                    total, bad;

   execute_mdu #(.XLEN(XLEN), .FWD_N(FWD_N)) dut (
      .cpu_clk   (cpu_clk),
      .cpu_rst   (cpu_rst),
      .valid_in  (valid_in),
      .flush     (flush),
      .rf_rD1    (rf_rD1),
      .rf_rD2    (rf_rD2),
      .pc        (pc),
      .ext       (ext),
      .alua_sel  (alua_sel),
      .alub_sel  (alub_sel),
      .alu_op    (alu_op),
      .md_en     (md_en),
      .md_op     (md_op),
      .forward_a (forward_a),
      .forward_b (forward_b),
      .fwd_data  (fwd_data),
      .ex_result (ex_result),
      .alu_f     (alu_f),
      .alu_src1  (alu_src1),
      .alu_src2  (alu_src2),
      .busy      (busy)
   );

   initial cpu_clk = 1'b0;
   always #5 cpu_clk = ~cpu_clk;

   // Reference: forwarding picks a slot from an array, everything else from the register file.
   function automatic logic [31:0] exp_src(input logic [1:0] sel, input logic [31:0] rf, input logic [63:0] fwd);
      logic [31:0] slots [2];
      slots[0] = fwd[31:0];
      slots[1] = fwd[63:32];
      if (sel == 2'd0 || int'(sel) > FWD_N) return rf;
      return slots[sel - 2'd1];
   endfunction

   function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
      case (op)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return a & b;
         4'd3:    return a | b;
         4'd4:    return a ^ b;
         4'd5:    return a << b[4:0];
         4'd6:    return a >> b[4:0];
         4'd7:    return $signed(a) >>> b[4:0];
         4'd8:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd9:    return (a < b) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic flag_ref(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
      case (op)
         4'd10:   return a == b;
         4'd11:   return a != b;
         4'd12:   return $signed(a) < $signed(b);
         4'd13:   return $signed(a) >= $signed(b);
         4'd14:   return a < b;
         4'd15:   return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] cur_a();
      return alua_sel ? pc : exp_src(forward_a, rf_rD1, fwd_data);
   endfunction

   function automatic logic [31:0] cur_b();
      return alub_sel ? ext : exp_src(forward_b, rf_rD2, fwd_data);
   endfunction

   function automatic logic [31:0] exp_ex();
      return alu_ref(cur_a(), cur_b(), alu_op);
   endfunction

   // M-extension results from 64-bit arithmetic plus the RISC-V corner-case rules.
   function automatic logic [31:0] mdu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint          sa, sb;
      longint unsigned ua, ub;
      logic [63:0]     p;
      logic            ovf;
      sa  = $signed(a);
      sb  = $signed(b);
      ua  = {32'd0, a};
      ub  = {32'd0, b};
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (op)
         3'd0: begin p = ua * ub; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * longint'(ub); return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin
            if (b == 0) return '1;
            if (ovf) return a;
            p = sa / sb; return p[31:0];
         end
         3'd5: return (b == 0) ? '1 : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (ovf) return 32'd0;
            p = sa % sb; return p[31:0];
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   task automatic randomize_alu();
      rf_rD1    = $urandom();
      rf_rD2    = $urandom();
      pc        = $urandom();
      ext       = $urandom();
      fwd_data  = {$urandom(), $urandom()};
      forward_a = 2'($urandom_range(0, 3));
      forward_b = 2'($urandom_range(0, 3));
      alua_sel  = 1'($urandom_range(0, 1));
      alub_sel  = 1'($urandom_range(0, 1));
      alu_op    = 4'($urandom_range(0, 15));
   endtask

   task automatic test_reset();
      cpu_rst  = 1'b1;
      flush    = 1'b0;
      valid_in = 1'b1;
      md_en    = 1'b1;
      md_op    = 3'd0;
      randomize_alu();
      #3;
      total++;
      if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
      total++;
      if (ex_result !== exp_ex()) begin bad++; $display("[TB] FAIL reset_ex_result: got %h expected %h", ex_result, exp_ex()); end
      total++;
      if (alu_src1 !== exp_src(forward_a, rf_rD1, fwd_data)) begin bad++; $display("[TB] FAIL reset_src1: got %h expected %h", alu_src1, exp_src(forward_a, rf_rD1, fwd_data)); end
      total++;
      if (alu_src2 !== exp_src(forward_b, rf_rD2, fwd_data)) begin bad++; $display("[TB] FAIL reset_src2: got %h expected %h", alu_src2, exp_src(forward_b, rf_rD2, fwd_data)); end
      valid_in = 1'b0;
      md_en    = 1'b0;
      @(negedge cpu_clk);
      cpu_rst = 1'b0;
   endtask

   task automatic test_forwarding();
      @(negedge cpu_clk);
      valid_in = 1'b0; md_en = 1'b0;
      forward_a = 2'd1; forward_b = 2'd0;
      fwd_data = {32'h0000_0077, 32'h0000_0010};
      rf_rD1 = 32'd5; rf_rD2 = 32'd3;
      alua_sel = 1'b0; alub_sel = 1'b0; alu_op = 4'd0;
      #1;
      total++;
      if (alu_src1 !== 32'h10) begin bad++; $display("[TB] FAIL fwd_slot0_src1: got %h expected 00000010", alu_src1); end
      total++;
      if (ex_result !== 32'h13) begin bad++; $display("[TB] FAIL fwd_slot0_add: got %h expected 00000013", ex_result); end
      forward_a = 2'd3;
      #1;
      total++;
      if (alu_src1 !== 32'd5) begin bad++; $display("[TB] FAIL fwd_out_of_range: got %h expected 00000005", alu_src1); end
      total++;
      if (ex_result !== 32'd8) begin bad++; $display("[TB] FAIL fwd_out_of_range_add: got %h expected 00000008", ex_result); end
      for (int i = 0; i < 24; i++) begin
         @(negedge cpu_clk);
         randomize_alu();
         valid_in = 1'($urandom_range(0, 1));
         #1;
         total++;
         if (alu_src1 !== exp_src(forward_a, rf_rD1, fwd_data)) begin bad++; $display("[TB] FAIL rand_src1[%0d]: got %h expected %h", i, alu_src1, exp_src(forward_a, rf_rD1, fwd_data)); end
         total++;
         if (alu_src2 !== exp_src(forward_b, rf_rD2, fwd_data)) begin bad++; $display("[TB] FAIL rand_src2[%0d]: got %h expected %h", i, alu_src2, exp_src(forward_b, rf_rD2, fwd_data)); end
         total++;
         if (ex_result !== exp_ex()) begin bad++; $display("[TB] FAIL rand_alu[%0d] op %0d: got %h expected %h", i, alu_op, ex_result, exp_ex()); end
         total++;
         if (alu_f !== flag_ref(cur_a(), cur_b(), alu_op)) begin bad++; $display("[TB] FAIL rand_flag[%0d] op %0d: got %b expected %b", i, alu_op, alu_f, flag_ref(cur_a(), cur_b(), alu_op)); end
      end
      valid_in = 1'b0;
   endtask

`ifdef EXECUTE_MDU_EN
   // Issue one M op from the register file, scramble inputs while stalled, check stall length and result.
   task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input string name);
      int          cycles;
      logic [31:0] exp;
      exp = mdu_ref(op, a, b);
      @(negedge cpu_clk);
      randomize_alu();
      rf_rD1 = a; rf_rD2 = b; forward_a = 2'd0; forward_b = 2'd0;
      md_op = op; md_en = 1'b1; valid_in = 1'b1; flush = 1'b0;
      cycles = 0;
      #1;
      while (busy === 1'b1 && cycles < 100) begin
         cycles++;
         @(negedge cpu_clk);
         randomize_alu();
         md_op = 3'($urandom_range(0, 7));
         #1;
      end
      total++;
      if (cycles !== 33) begin bad++; $display("[TB] FAIL %s_stall: got %0d cycles expected 33", name, cycles); end
      total++;
      if (ex_result !== exp) begin bad++; $display("[TB] FAIL %s_result: got %h expected %h", name, ex_result, exp); end
      valid_in = 1'b0; md_en = 1'b0;
      @(negedge cpu_clk);
      #1;
      total++;
      if (busy !== 1'b0 || ex_result !== exp_ex()) begin bad++; $display("[TB] FAIL %s_after_done: got busy=%b ex=%h expected busy=0 ex=%h", name, busy, ex_result, exp_ex()); end
   endtask

   task automatic test_mdu_ops();
      logic [2:0]  op;
      logic [31:0] a, b;
      run_md(3'd0, 32'd7, 32'hFFFF_FFFD, "mul_spec");
      run_md(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_spec");
      run_md(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
      run_md(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "rem_overflow");
      run_md(3'd5, 32'd100, 32'd0, "divu_by_zero");
      run_md(3'd7, 32'd100, 32'd0, "remu_by_zero");
      run_md(3'd4, -32'sd7, 32'd2, "div_neg");
      run_md(3'd6, -32'sd7, 32'd2, "rem_neg");
      run_md(3'd4, -32'sd7, 32'd0, "div_neg_by_zero");
      for (int i = 0; i < 12; i++) begin
         op = 3'($urandom_range(0, 7));
         a  = $urandom();
         b  = $urandom();
         if (i % 4 == 1) b = 32'd0;
         if (i % 4 == 2) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
         if (i % 4 == 3) b = $urandom_range(1, 20);
         run_md(op, a, b, $sformatf("rand%0d_op%0d", i, op));
      end
   endtask

   task automatic test_flush();
      @(negedge cpu_clk);
      randomize_alu();
      forward_a = 2'd0; forward_b = 2'd0;
      md_op = 3'd0; md_en = 1'b1; valid_in = 1'b1; flush = 1'b0;
      repeat (10) @(negedge cpu_clk);
      flush = 1'b1;
      @(negedge cpu_clk);
      flush = 1'b0; valid_in = 1'b0; md_en = 1'b0;
      #1;
      total++;
      if (busy !== 1'b0) begin bad++; $display("[TB] FAIL flush_busy: got %b expected 0", busy); end
      total++;
      if (ex_result !== exp_ex()) begin bad++; $display("[TB] FAIL flush_ex_result: got %h expected %h", ex_result, exp_ex()); end
      run_md(3'd0, $urandom(), $urandom(), "mul_after_flush");
      @(negedge cpu_clk);
      md_op = 3'd4; md_en = 1'b1; valid_in = 1'b1; flush = 1'b1;
      #1;
      total++;
      if (busy !== 1'b0) begin bad++; $display("[TB] FAIL flush_issue_busy: got %b expected 0", busy); end
      @(negedge cpu_clk);
      flush = 1'b0; valid_in = 1'b0; md_en = 1'b0;
      #1;
      total++;
      if (busy !== 1'b0) begin bad++; $display("[TB] FAIL flush_issue_no_start: got %b expected 0", busy); end
   endtask

   task automatic test_async_reset();
      @(negedge cpu_clk);
      randomize_alu();
      md_op = 3'd5; md_en = 1'b1; valid_in = 1'b1; flush = 1'b0;
      repeat (5) @(negedge cpu_clk);
      #2;
      cpu_rst = 1'b1;
      #1;
      total++;
      if (busy !== 1'b0) begin bad++; $display("[TB] FAIL async_reset_busy: got %b expected 0", busy); end
      total++;
      if (ex_result !== exp_ex()) begin bad++; $display("[TB] FAIL async_reset_ex: got %h expected %h", ex_result, exp_ex()); end
      valid_in = 1'b0; md_en = 1'b0;
      #1;
      cpu_rst = 1'b0;
      run_md(3'd1, $urandom(), $urandom(), "mulh_after_reset");
   endtask
`else
   task automatic test_no_mdu();
      for (int i = 0; i < 8; i++) begin
         @(negedge cpu_clk);
         randomize_alu();
         md_op = 3'($urandom_range(0, 7)); md_en = 1'b1; valid_in = 1'b1; flush = 1'b0;
         #1;
         total++;
         if (busy !== 1'b0) begin bad++; $display("[TB] FAIL no_mdu_busy[%0d]: got %b expected 0", i, busy); end
         @(negedge cpu_clk);
         #1;
         total++;
         if (ex_result !== exp_ex()) begin bad++; $display("[TB] FAIL no_mdu_ex[%0d]: got %h expected %h", i, ex_result, exp_ex()); end
      end
      valid_in = 1'b0; md_en = 1'b0;
   endtask
`endif

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_forwarding();
`ifdef EXECUTE_MDU_EN
      test_mdu_ops();
      test_flush();
      test_async_reset();
`else
      test_no_mdu();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
